bfly_pair_feeder: RTL and testbench
===================================

# bfly_pair_feeder

Input stage for the FFT datapath, directly upstream of `complex_butterfly`. It collects one frame of N complex samples into a double-buffered register bank. For each butterfly index k it then issues the pair (x[k], x[k+N/2]) with the twiddle W_N^k. The frame is streamed in with valid/ready; the pairs leave with valid/ready, so the next frame fills while the current one drains.

## Interface
- `LOG2N`, 3, log2 of frame length N; supported 2..4
- `DW`, 8, sample/twiddle component width; signed two's complement
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `in_re`, `in_im`  in  DW each  input sample, real/imag
- `in_valid`  in  1  sample present
- `in_ready`  out  1  sample accepted when `in_valid && in_ready` at a rising edge
- `a_re`, `a_im`  out  DW each  butterfly top input x[k] (drives `a_in[0]`/`a_in[1]`)
- `b_re`, `b_im`  out  DW each  butterfly bottom input x[k+N/2] (drives `b_in[0]`/`b_in[1]`)
- `w_re`, `w_im`  out  DW each  twiddle W_N^k, Q1.7 (drives `weights[0]`/`weights[1]`)
- `out_k`  out  LOG2N-1  butterfly index k
- `out_last`  out  1  high with k = N/2-1
- `out_valid`  out  1  pair present
- `out_ready`  in  1  pair consumed when `out_valid && out_ready` at a rising edge

## Operation
- Storage: two banks, each N×(2·DW) registers, with per-bank `full` flags. Sample n of a frame is written to address n.
- Write side:
  - `wbank`/`wcnt` point at the next slot; `in_ready = !full[wbank]`, forced 0 while `reset` is high.
  - On accept, write the sample and increment `wcnt`.
  - At `wcnt == N-1`: set `full[wbank]`, toggle `wbank`, `wcnt` ← 0.
- Read FSM states: IDLE, ISSUE.
  - IDLE: `out_valid` = 0. If `full[rbank]`, load pair 0 of `rbank` into the output registers and go to ISSUE.
  - ISSUE: `out_valid` = 1; all outputs are held stable while `out_ready` = 0.
    - Transfer with k < N/2-1: load pair k+1.
    - Transfer with k = N/2-1: clear `full[rbank]` and toggle `rbank`. If the other bank's `full` is already set at that edge, load its pair 0 and stay in ISSUE; otherwise go to IDLE.
- Twiddle: ROM of 8 entries for N=16, indexed by k·(16/N).
  - Entries (re, im): (127,0) (118,−49) (91,−91) (49,−118) (0,−127) (−49,−118) (−91,−91) (−118,−49).
  - +1.0 saturates to 127.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: `out_valid`, `out_last`, `out_k`, all data outputs 0; `full` = 0; `wbank` = `rbank` = 0; `wcnt` = 0; FSM in IDLE.
- Latency: when the N-th sample is accepted at edge E, pair 0 is valid after edge E+1.
- Same-edge events:
  - A bank filling at the same edge the other bank releases its last pair: not seen by the read side; `out_valid` drops for exactly 1 cycle, then pair 0 appears.
  - A release at edge E: `in_ready` may rise after E, even with a fill attempt at E.
- Throughput: 1 pair/cycle with `out_ready` held high. Frames stream gap-free on input while a bank is free.
- Both banks full: `in_ready` = 0 until the first release.
- Reset asserted mid-frame or mid-drain: outputs clear immediately (asynchronous), partial frames are discarded, and the first sample after release goes to bank 0, address 0.

## Structure
- Shared package `fft_pkg`: `DW`, the complex-sample typedef, the 16-point twiddle table constant, and the ROM stride function.
- One sub-module, `bfly_twiddle_rom`: k, LOG2N → (w_re, w_im), combinational, registered in the parent's output stage.

## Test plan
- Single frame, LOG2N=3, x[n] = (n, −n), `out_ready` = 1:
  - 4 pairs on consecutive cycles, starting 1 cycle after the 8th accept.
  - k=1: a=(1,−1), b=(5,−5), w=(0x5B,0xA5).
  - k=3: a=(3,−3), b=(7,−7), w=(0xA5,0xA5), `out_last` = 1.
- Backpressure: `out_ready` toggling 1/0 → each pair is held stable while stalled; no pair is lost or duplicated; 4 transfers total.
- Three back-to-back frames with `out_ready` = 0 → `in_ready` falls after 16 accepts. After `out_ready` rises, frames 1 and 2 drain in order, and the third frame is accepted once bank 0 releases.
- LOG2N=2, x[n] = (10+n, 0) → k=0: a=(10,0), b=(12,0), w=(0x7F,0x00); k=1: a=(11,0), b=(13,0), w=(0x00,0x81).
- `reset` pulsed after 5 samples and again during pair 2 → outputs read 0 within the reset cycle; the next full frame is issued correctly from address 0.
- Same-edge boundary: last pair released at the same edge the other bank fills → exactly one `out_valid` = 0 cycle, then pair 0 of the new frame.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared FFT datapath definitions. Holds the component width,
//                the complex-sample type, the 16-point twiddle table and the
//                stride function that maps a butterfly index of an N-point
//                frame onto the 16-point table.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Sample and twiddle component width, signed two's complement.
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Table is built for the largest supported frame (N = 16).
    localparam int c_tw_log2n = 4;

    // W_16^i = cos(2*pi*i/16) - j*sin(2*pi*i/16) in Q1.7; +1.0 saturates to 127.
    localparam cplx_t c_twiddle16 [8] = '{
        '{re: 8'h7F, im: 8'h00},   // (  127,    0)
        '{re: 8'h76, im: 8'hCF},   // (  118,  -49)
        '{re: 8'h5B, im: 8'hA5},   // (   91,  -91)
        '{re: 8'h31, im: 8'h8A},   // (   49, -118)
        '{re: 8'h00, im: 8'h81},   // (    0, -127)
        '{re: 8'hCF, im: 8'h8A},   // (  -49, -118)
        '{re: 8'hA5, im: 8'hA5},   // (  -91,  -91)
        '{re: 8'h8A, im: 8'hCF}    // ( -118,  -49)
    };

    // W_N^k equals W_16^(k*16/N); the stride is a left shift by (4 - log2 N).
    function automatic logic [2:0] twiddle_index(input logic [2:0] k, input int log2n);
        return 3'(k << (c_tw_log2n - log2n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfly_pair_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bfly_pair_feeder_if
//  Description : Stream interface of the butterfly pair feeder.
//                Input side : in_re/in_im/in_valid -> in_ready
//                Output side: a_*, b_*, w_*, out_k, out_last, out_valid
//                             -> out_ready
//                slave modport is the feeder, master modport its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bfly_pair_feeder_if import fft_pkg::*; #(
    parameter int LOG2N = 3
);
    logic [DW-1:0]    in_re;
    logic [DW-1:0]    in_im;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    a_re;
    logic [DW-1:0]    a_im;
    logic [DW-1:0]    b_re;
    logic [DW-1:0]    b_im;
    logic [DW-1:0]    w_re;
    logic [DW-1:0]    w_im;
    logic [LOG2N-2:0] out_k;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_re, in_im, in_valid, out_ready,
        output in_ready, a_re, a_im, b_re, b_im, w_re, w_im,
               out_k, out_last, out_valid
    );

    modport master (
        output in_re, in_im, in_valid, out_ready,
        input  in_ready, a_re, a_im, b_re, b_im, w_re, w_im,
               out_k, out_last, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/bfly_twiddle_rom.sv
`default_nettype none
// ============================================================================
//  Module      : bfly_twiddle_rom
//  Description : Combinational twiddle lookup W_N^k for N = 2^LOG2N.
//  Ports       : i_k    - butterfly index k (LOG2N-1 bits)
//                o_w_re - twiddle real part, Q1.7
//                o_w_im - twiddle imaginary part, Q1.7
//  Revision    : 1.0 - initial release
// ============================================================================
module bfly_twiddle_rom import fft_pkg::*; #(
    parameter int LOG2N = 3
) (
    input  wire logic [LOG2N-2:0] i_k,
    output logic      [DW-1:0]    o_w_re,
    output logic      [DW-1:0]    o_w_im
);
    logic [2:0] w_idx;

    assign w_idx  = twiddle_index(3'(i_k), LOG2N);
    assign o_w_re = c_twiddle16[w_idx].re;
    assign o_w_im = c_twiddle16[w_idx].im;
endmodule
`default_nettype wire

// File: rtl/bfly_pair_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : bfly_pair_feeder
//  Description : Double-buffered frame collector ahead of complex_butterfly.
//                Fills one bank with N samples while the other bank issues
//                the pairs (x[k], x[k+N/2]) together with W_N^k.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - stream interface (slave side): sample input with
//                        valid/ready, pair output with valid/ready
//  Revision    : 1.0 - initial release
// ============================================================================
module bfly_pair_feeder import fft_pkg::*; #(
    parameter int LOG2N = 3
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bfly_pair_feeder_if.slave   bus
);
    localparam int               c_n         = 1 << LOG2N;
    localparam int               c_kw        = LOG2N - 1;
    localparam logic [LOG2N-1:0] c_wcnt_last = LOG2N'(c_n - 1);
    localparam logic [c_kw-1:0]  c_k_last    = c_kw'((c_n / 2) - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_issue = 1'b1;

    cplx_t            r_mem [2][c_n];
    logic [1:0]       r_full;
    logic             r_wbank;
    logic             r_rbank;
    logic [LOG2N-1:0] r_wcnt;
    logic [0:0]       r_state;
    cplx_t            r_a;
    cplx_t            r_b;
    logic [DW-1:0]    r_w_re;
    logic [DW-1:0]    r_w_im;
    logic [c_kw-1:0]  r_k;
    logic             r_last;
    logic             r_valid;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_fill;
    logic             w_release;
    logic             w_load;
    logic             w_load_bank;
    logic [c_kw-1:0]  w_load_k;
    logic [0:0]       w_state_nxt;
    logic [DW-1:0]    w_rom_re;
    logic [DW-1:0]    w_rom_im;

    // ---------------------------------------------------------------- write
    assign bus.in_ready = !r_full[r_wbank] && !reset;
    assign w_in_fire    = bus.in_valid && bus.in_ready;
    assign w_fill       = w_in_fire && (r_wcnt == c_wcnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else if (w_in_fire) begin
            r_mem[r_wbank][r_wcnt] <= '{re: bus.in_re, im: bus.in_im};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbank <= 1'b0;
            r_wcnt  <= '0;
        end else if (w_in_fire) begin
            if (w_fill) begin
                r_wbank <= !r_wbank;
                r_wcnt  <= '0;
            end else begin
                r_wcnt  <= r_wcnt + 1'b1;
            end
        end
    end

    // Fill and release can never hit the same bank on one edge: a fill needs
    // the write bank empty, a release needs the read bank full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= '0;
        end else begin
            if (w_fill)    r_full[r_wbank] <= 1'b1;
            if (w_release) r_full[r_rbank] <= 1'b0;
        end
    end

    // ----------------------------------------------------------------- read
    assign w_out_fire = r_valid && bus.out_ready;

    // Decides which pair (bank, k) is loaded into the output stage this edge.
    // The other bank's full flag is sampled as registered, so a bank filling
    // on the very edge of a release is picked up one cycle later from IDLE.
    always_comb begin
        w_load      = 1'b0;
        w_load_bank = r_rbank;
        w_load_k    = '0;
        w_release   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_full[r_rbank]) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_out_fire) begin
                    if (r_k != c_k_last) begin
                        w_load   = 1'b1;
                        w_load_k = r_k + 1'b1;
                    end else begin
                        w_release = 1'b1;
                        if (r_full[!r_rbank]) begin
                            w_load      = 1'b1;
                            w_load_bank = !r_rbank;
                        end else begin
                            w_state_nxt = c_st_idle;
                        end
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    bfly_twiddle_rom #(
        .LOG2N (LOG2N)
    ) u_twiddle_rom (
        .i_k    (w_load_k),
        .o_w_re (w_rom_re),
        .o_w_im (w_rom_im)
    );

    // Output stage; x[k] sits in the lower half of a bank, x[k+N/2] in the
    // upper half, so the MSB of the address selects top/bottom input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_rbank <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_w_re  <= '0;
            r_w_im  <= '0;
            r_k     <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == c_st_issue);
            if (w_release) r_rbank <= !r_rbank;
            if (w_load) begin
                r_a    <= r_mem[w_load_bank][{1'b0, w_load_k}];
                r_b    <= r_mem[w_load_bank][{1'b1, w_load_k}];
                r_w_re <= w_rom_re;
                r_w_im <= w_rom_im;
                r_k    <= w_load_k;
                r_last <= (w_load_k == c_k_last);
            end
        end
    end

    assign bus.a_re      = r_a.re;
    assign bus.a_im      = r_a.im;
    assign bus.b_re      = r_b.re;
    assign bus.b_im      = r_b.im;
    assign bus.w_re      = r_w_re;
    assign bus.w_im      = r_w_im;
    assign bus.out_k     = r_k;
    assign bus.out_last  = r_last;
    assign bus.out_valid = r_valid;
endmodule
`default_nettype wire

// File: tb/tb_bfly_pair_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bfly_pair_feeder
//  Description : Self-checking bench for bfly_pair_feeder with N = 8 and N = 4
//                instances. Expected pairs come from a frame-level model:
//                accepted samples are grouped into frames of N and turned
//                into (x[k], x[k+N/2], W_N^k) with the twiddle computed from
//                cos/sin in real arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bfly_pair_feeder;
    import fft_pkg::*;

    typedef struct packed {
        logic [7:0] ar, ai, br, bi, wr, wi;
        logic [2:0] k;
        logic       last;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bfly_pair_feeder_if #(.LOG2N(3)) bus3 ();
    bfly_pair_feeder_if #(.LOG2N(2)) bus2 ();

    bfly_pair_feeder #(.LOG2N(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
    bfly_pair_feeder #(.LOG2N(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    int          n_cmp = 0;
    int          n_err = 0;
    int          acc3  = 0;
    bit          sender_done;
    logic [15:0] frame3 [$];
    logic [15:0] frame2 [$];
    pair_t       exp3 [$];
    pair_t       obs3 [$];
    pair_t       exp2 [$];
    pair_t       obs2 [$];

    // ------------------------------------------------------------ model
    function automatic int q17(input real v);
        int r;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        if (r > 127) r = 127;
        return r;
    endfunction

    function automatic pair_t model_pair(input logic [15:0] xa, input logic [15:0] xb,
                                         input int k, input int n);
        pair_t p;
        real   ang;
        ang    = 2.0 * 3.14159265358979 * $itor(k) / $itor(n);
        p.ar   = xa[15:8];
        p.ai   = xa[7:0];
        p.br   = xb[15:8];
        p.bi   = xb[7:0];
        p.wr   = 8'(q17($cos(ang) * 128.0));
        p.wi   = 8'(-q17($sin(ang) * 128.0));
        p.k    = 3'(k);
        p.last = (k == n / 2 - 1);
        return p;
    endfunction

    function automatic pair_t cur3();
        return '{bus3.a_re, bus3.a_im, bus3.b_re, bus3.b_im, bus3.w_re, bus3.w_im,
                 3'(bus3.out_k), bus3.out_last};
    endfunction

    function automatic pair_t cur2();
        return '{bus2.a_re, bus2.a_im, bus2.b_re, bus2.b_im, bus2.w_re, bus2.w_im,
                 3'(bus2.out_k), bus2.out_last};
    endfunction

    // Collect accepted samples and transferred pairs (sampled mid-cycle).
    always @(negedge clk) begin
        if (!reset) begin
            if (bus3.in_valid && bus3.in_ready) begin
                frame3.push_back({bus3.in_re, bus3.in_im});
                acc3++;
                if (frame3.size() == 8) begin
                    for (int k = 0; k < 4; k++) exp3.push_back(model_pair(frame3[k], frame3[k+4], k, 8));
                    frame3.delete();
                end
            end
            if (bus3.out_valid && bus3.out_ready) obs3.push_back(cur3());
            if (bus2.in_valid && bus2.in_ready) begin
                frame2.push_back({bus2.in_re, bus2.in_im});
                if (frame2.size() == 4) begin
                    for (int k = 0; k < 2; k++) exp2.push_back(model_pair(frame2[k], frame2[k+2], k, 4));
                    frame2.delete();
                end
            end
            if (bus2.out_valid && bus2.out_ready) obs2.push_back(cur2());
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------ drivers
    task automatic clear_model();
        frame3.delete(); exp3.delete(); obs3.delete();
        frame2.delete(); exp2.delete(); obs2.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        bus3.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        clear_model();
    endtask

    task automatic push(input bit sel2, input logic [7:0] re, input logic [7:0] im);
        bit done;
        done = 1'b0;
        if (sel2) begin bus2.in_re = re; bus2.in_im = im; bus2.in_valid = 1'b1; end
        else      begin bus3.in_re = re; bus3.in_im = im; bus3.in_valid = 1'b1; end
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = sel2 ? bus2.in_ready : bus3.in_ready;
            @(posedge clk); #1;
        end
        if (sel2) bus2.in_valid = 1'b0; else bus3.in_valid = 1'b0;
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL push_accept: in_ready=0 for 200 cycles, required 1"); end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        @(posedge clk); #1; reset = 1'b1; #2;
        n_cmp++;
        if ({cur3(), bus3.out_valid, bus3.in_ready} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h, required 0", {cur3(), bus3.out_valid, bus3.in_ready});
        end
        @(posedge clk); #1; reset = 1'b0; #1;
        n_cmp++;
        if (bus3.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b%b, required 11", bus3.in_ready, bus2.in_ready);
        end
        clear_model();
    endtask

    task automatic test_single_frame();
        pair_t p;
        do_reset();
        bus3.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) push(1'b0, 8'(n), 8'(-n));
        #1;
        n_cmp++;
        if (bus3.out_valid !== 1'b0) begin n_err++; $display("FAIL single_latency_early: out_valid=%b, required 0", bus3.out_valid); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            n_cmp++;
            if (bus3.out_valid !== 1'b1 || bus3.out_k !== 2'(k)) begin
                n_err++; $display("FAIL single_stream: valid=%b k=%0d, required 1/%0d", bus3.out_valid, bus3.out_k, k);
            end
        end
        @(posedge clk); #2;
        n_cmp++;
        if (bus3.out_valid !== 1'b0) begin n_err++; $display("FAIL single_end: out_valid=%b, required 0", bus3.out_valid); end
        n_cmp++;
        if (obs3.size() != 4 || exp3.size() != 4) begin n_err++; $display("FAIL single_count: got %0d, required 4", obs3.size()); end
        for (int i = 0; i < exp3.size(); i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL single_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
        p = (obs3.size() > 1) ? obs3[1] : '0;
        n_cmp++;
        if (p !== pair_t'{8'h01, 8'hFF, 8'h05, 8'hFB, 8'h5B, 8'hA5, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL single_k1: got %h", p);
        end
        p = (obs3.size() > 3) ? obs3[3] : '0;
        n_cmp++;
        if (p !== pair_t'{8'h03, 8'hFD, 8'h07, 8'hF9, 8'hA5, 8'hA5, 3'd3, 1'b1}) begin
            n_err++; $display("FAIL single_k3: got %h", p);
        end
    endtask

    task automatic test_backpressure();
        pair_t snap, cur, p;
        bit    held;
        do_reset();
        for (int n = 0; n < 8; n++) push(1'b0, 8'($urandom), 8'($urandom));
        repeat (2) begin @(posedge clk); #1; end
        held = 1'b0;
        snap = '0;
        for (int c = 0; c < 20; c++) begin
            bus3.out_ready = (c % 2 == 0);
            @(negedge clk);
            cur = cur3();
            if (held) begin
                n_cmp++;
                if (cur !== snap || bus3.out_valid !== 1'b1) begin
                    n_err++; $display("FAIL bp_stable: got %h valid=%b, required %h valid=1", cur, bus3.out_valid, snap);
                end
            end
            held = bus3.out_valid && !bus3.out_ready;
            snap = cur;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (obs3.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d transfers, required 4", obs3.size()); end
        for (int i = 0; i < exp3.size(); i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL bp_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
    endtask

    task automatic test_back_to_back();
        pair_t p;
        do_reset();
        acc3        = 0;
        sender_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) push(1'b0, 8'($urandom), 8'($urandom));
                sender_done = 1'b1;
            end
        join_none
        repeat (30) @(posedge clk);
        #2;
        n_cmp++;
        if (acc3 != 16 || bus3.in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_full: accepts=%0d in_ready=%b, required 16/0", acc3, bus3.in_ready);
        end
        bus3.out_ready = 1'b1;
        for (int t = 0; t < 5000 && !(sender_done && obs3.size() >= 12); t++) @(posedge clk);
        #2;
        n_cmp++;
        if (!sender_done || obs3.size() != 12 || exp3.size() != 12) begin
            n_err++; $display("FAIL b2b_count: done=%b transfers=%0d, required 1/12", sender_done, obs3.size());
        end
        for (int i = 0; i < exp3.size(); i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL b2b_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
    endtask

    task automatic test_small_frame();
        pair_t p;
        do_reset();
        bus2.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) push(1'b1, 8'(10 + n), 8'd0);
        for (int t = 0; t < 20 && obs2.size() < 2; t++) @(posedge clk);
        #2;
        n_cmp++;
        if (obs2.size() != 2) begin n_err++; $display("FAIL n4_count: got %0d, required 2", obs2.size()); end
        for (int i = 0; i < exp2.size(); i++) begin
            p = (i < obs2.size()) ? obs2[i] : '0;
            n_cmp++;
            if (p !== exp2[i]) begin n_err++; $display("FAIL n4_pair%0d: got %h, required %h", i, p, exp2[i]); end
        end
        p = (obs2.size() > 0) ? obs2[0] : '0;
        n_cmp++;
        if (p !== pair_t'{8'd10, 8'd0, 8'd12, 8'd0, 8'h7F, 8'h00, 3'd0, 1'b0}) begin
            n_err++; $display("FAIL n4_k0: got %h", p);
        end
        p = (obs2.size() > 1) ? obs2[1] : '0;
        n_cmp++;
        if (p !== pair_t'{8'd11, 8'd0, 8'd13, 8'd0, 8'h00, 8'h81, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL n4_k1: got %h", p);
        end
    endtask

    task automatic test_reset_mid();
        pair_t p;
        do_reset();
        for (int n = 0; n < 5; n++) push(1'b0, 8'($urandom), 8'($urandom));
        reset = 1'b1; #1;
        n_cmp++;
        if (bus3.in_ready !== 1'b0 || bus3.out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst1_outputs: in_ready=%b valid=%b, required 0/0", bus3.in_ready, bus3.out_valid);
        end
        @(posedge clk); #1; reset = 1'b0;
        clear_model();
        for (int n = 0; n < 8; n++) push(1'b0, 8'($urandom), 8'($urandom));
        repeat (2) begin @(posedge clk); #1; end
        bus3.out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus3.out_ready = 1'b0; #1;
        n_cmp++;
        if (bus3.out_valid !== 1'b1 || bus3.out_k !== 2'd2) begin
            n_err++; $display("FAIL rst2_pre: valid=%b k=%0d, required 1/2", bus3.out_valid, bus3.out_k);
        end
        for (int i = 0; i < 2; i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL rst2_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
        reset = 1'b1; #1;
        n_cmp++;
        if ({cur3(), bus3.out_valid} !== '0) begin
            n_err++; $display("FAIL rst2_outputs: got %h, required 0", {cur3(), bus3.out_valid});
        end
        @(posedge clk); #1; reset = 1'b0;
        clear_model();
        bus3.out_ready = 1'b1;
        for (int n = 0; n < 8; n++) push(1'b0, 8'($urandom), 8'($urandom));
        for (int t = 0; t < 20 && obs3.size() < 4; t++) @(posedge clk);
        #2;
        n_cmp++;
        if (obs3.size() != 4) begin n_err++; $display("FAIL rst_after_count: got %0d, required 4", obs3.size()); end
        for (int i = 0; i < exp3.size(); i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL rst_after_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
    endtask

    task automatic test_same_edge();
        pair_t p;
        do_reset();
        for (int n = 0; n < 15; n++) push(1'b0, 8'($urandom), 8'($urandom));
        bus3.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (bus3.out_valid !== 1'b1 || bus3.out_last !== 1'b1) begin
            n_err++; $display("FAIL edge_pre: valid=%b last=%b, required 1/1", bus3.out_valid, bus3.out_last);
        end
        bus3.in_re    = 8'($urandom);
        bus3.in_im    = 8'($urandom);
        bus3.in_valid = 1'b1;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0; #1;
        n_cmp++;
        if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1) begin
            n_err++; $display("FAIL edge_gap: valid=%b in_ready=%b, required 0/1", bus3.out_valid, bus3.in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (bus3.out_valid !== 1'b1 || bus3.out_k !== 2'd0) begin
            n_err++; $display("FAIL edge_resume: valid=%b k=%0d, required 1/0", bus3.out_valid, bus3.out_k);
        end
        for (int t = 0; t < 20 && obs3.size() < 8; t++) @(posedge clk);
        #2;
        n_cmp++;
        if (obs3.size() != 8 || exp3.size() != 8) begin n_err++; $display("FAIL edge_count: got %0d, required 8", obs3.size()); end
        for (int i = 0; i < exp3.size(); i++) begin
            p = (i < obs3.size()) ? obs3[i] : '0;
            n_cmp++;
            if (p !== exp3[i]) begin n_err++; $display("FAIL edge_pair%0d: got %h, required %h", i, p, exp3[i]); end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus3.in_re     = '0;
        bus3.in_im     = '0;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b0;
        bus2.in_re     = '0;
        bus2.in_im     = '0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;

        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_small_frame();
        test_reset_mid();
        test_same_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
